// File: rtl/tbb_pp_pkg.sv
// tbb_pp_pkg: shared definitions for the tbb_pp ping-pong task batch buffer.
//   - one-hot fill-state encodings (RESET/REQ/FILL/HOLD) and their enum type
//   - lane_bits(): number of lane-select bits, log2(line width / word width)
//   - params_legal(): elaboration-time legality check of the geometry
package tbb_pp_pkg;

    localparam logic [3:0] FS_RESET = 4'b0001;
    localparam logic [3:0] FS_REQ   = 4'b0010;
    localparam logic [3:0] FS_FILL  = 4'b0100;
    localparam logic [3:0] FS_HOLD  = 4'b1000;

    typedef enum logic [3:0] {
        S_RESET = FS_RESET,
        S_REQ   = FS_REQ,
        S_FILL  = FS_FILL,
        S_HOLD  = FS_HOLD
    } fill_state_t;

    function automatic int lane_bits(input int wr_width, input int rd_width);
        return $clog2(wr_width / rd_width);
    endfunction

    // Word width must divide the line width with a power-of-2 ratio, and the
    // batch must fit inside one bank.
    function automatic bit params_legal(input int addr_width, input int wr_width,
                                        input int rd_width, input int num_lines);
        int ratio;
        if (rd_width <= 0 || wr_width <= 0) return 1'b0;
        if ((wr_width % rd_width) != 0) return 1'b0;
        ratio = wr_width / rd_width;
        if ((ratio & (ratio - 1)) != 0) return 1'b0;
        if (num_lines < 1 || num_lines > (1 << addr_width)) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/tbb_pp_if.sv
// tbb_pp_if: request/write/task/read bundle of the tbb_pp batch buffer.
//   master : the fill engine + PE array side (drives ReqAck, WrEn/WrAddr/WrDin,
//            task_done, RdAddr)
//   slave  : the buffer itself (drives ReqValid/ReqLineIdx/ReqBank,
//            task_start/task_bank, RdDout, Full, Empty, err)
interface tbb_pp_if #(
    parameter int WR_ADDR_WIDTH = 12,
    parameter int WR_DATA_WIDTH = 512,
    parameter int RD_DATA_WIDTH = 32,
    parameter int RD_ADDR_WIDTH = 16
);
    logic                     ReqValid;
    logic [WR_ADDR_WIDTH-1:0] ReqLineIdx;
    logic                     ReqBank;
    logic                     ReqAck;
    logic                     WrEn;
    logic [WR_ADDR_WIDTH-1:0] WrAddr;
    logic [WR_DATA_WIDTH-1:0] WrDin;
    logic                     task_start;
    logic                     task_bank;
    logic                     task_done;
    logic [RD_ADDR_WIDTH-1:0] RdAddr;
    logic [RD_DATA_WIDTH-1:0] RdDout;
    logic                     Full;
    logic                     Empty;
    logic [2:0]               err;

    modport master (
        input  ReqValid, ReqLineIdx, ReqBank, task_start, task_bank, RdDout, Full, Empty, err,
        output ReqAck, WrEn, WrAddr, WrDin, task_done, RdAddr
    );

    modport slave (
        output ReqValid, ReqLineIdx, ReqBank, task_start, task_bank, RdDout, Full, Empty, err,
        input  ReqAck, WrEn, WrAddr, WrDin, task_done, RdAddr
    );
endinterface

// File: rtl/nlb_gram_sdp.sv
// nlb_gram_sdp: simple dual-port RAM, one write port and one read port with
// a registered read (1-cycle latency).
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data : write address/data
//   rd_addr : read address, rd_data : read data (registered)
module nlb_gram_sdp #(
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8192,
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/tbb_lane_mux.sv
// tbb_lane_mux: picks one RD word out of a registered memory line.
// The lane index is registered so it lines up with the RAM's registered read.
//   clk  : clock
//   lane : lane index, sampled together with the RAM read address
//   line : registered RAM output line
//   word : selected word, lane k = line[k*WORD_WIDTH +: WORD_WIDTH]
module tbb_lane_mux #(
    parameter int LINE_WIDTH = 512,
    parameter int WORD_WIDTH = 32,
    parameter int LANE_BITS  = 4,
    localparam int SEL_W     = (LANE_BITS > 0) ? LANE_BITS : 1,
    localparam int NUM_LANES = 1 << LANE_BITS
) (
    input  logic                  clk,
    input  logic [SEL_W-1:0]      lane,
    input  logic [LINE_WIDTH-1:0] line,
    output logic [WORD_WIDTH-1:0] word
);
    logic [WORD_WIDTH-1:0] words [NUM_LANES];

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign words[gi] = line[gi*WORD_WIDTH +: WORD_WIDTH];
    end

    if (LANE_BITS == 0) begin : g_single
        assign word = words[0];
    end else begin : g_multi
        logic [SEL_W-1:0] lane_reg;
        always_ff @(posedge clk) begin
            lane_reg <= lane;
        end
        assign word = words[lane_reg];
    end
endmodule

// File: rtl/tbb_pp.sv
// tbb_pp: ping-pong task batch buffer for one PE array. One bank is filled by
// line requests and wide writes while the PE array reads the other bank.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : request, write, task handoff and read signals (tbb_pp_if)
// Optional feature: define TBB_PP_ERR_EN to get sticky error flags on err
// (err[0] write dropped, err[1] stray ack, err[2] stray task_done);
// otherwise err is constant zero.
module tbb_pp
    import tbb_pp_pkg::*;
#(
    parameter int WR_ADDR_WIDTH = 12,
    parameter int WR_DATA_WIDTH = 512,
    parameter int RD_DATA_WIDTH = 32,
    parameter int NUM_LINES     = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    tbb_pp_if.slave     bus
);
    localparam int LANE_BITS     = lane_bits(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int RD_ADDR_WIDTH = WR_ADDR_WIDTH + LANE_BITS;
    localparam int SEL_W         = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam bit PARAMS_OK     = params_legal(WR_ADDR_WIDTH, WR_DATA_WIDTH,
                                                RD_DATA_WIDTH, NUM_LINES);
    localparam logic [WR_ADDR_WIDTH-1:0] LAST_LINE = WR_ADDR_WIDTH'(NUM_LINES - 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("tbb_pp: illegal parameter combination");
    end

    fill_state_t              state_reg, state_next;
    logic                     fill_bank_reg, fill_bank_next;
    logic                     task_bank_reg, task_bank_next;
    logic                     exec_busy_reg, exec_busy_next;
    logic [WR_ADDR_WIDTH-1:0] req_cnt_reg, req_cnt_next;
    logic [WR_ADDR_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;

    logic ack_ok, wr_ok, batch_done, handoff;

    assign ack_ok     = (state_reg == S_REQ) && bus.ReqAck;
    assign wr_ok      = bus.WrEn && ((state_reg == S_REQ) || (state_reg == S_FILL));
    assign batch_done = wr_ok && (wr_cnt_reg == LAST_LINE);
    // A task_done arriving with the final write frees the executor in the same
    // cycle, so the new batch is handed off without passing through HOLD.
    assign handoff    = (batch_done && (!exec_busy_reg || bus.task_done)) ||
                        ((state_reg == S_HOLD) && bus.task_done);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= S_RESET;
            fill_bank_reg <= 1'b0;
            task_bank_reg <= 1'b0;
            exec_busy_reg <= 1'b0;
            req_cnt_reg   <= '0;
            wr_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            fill_bank_reg <= fill_bank_next;
            task_bank_reg <= task_bank_next;
            exec_busy_reg <= exec_busy_next;
            req_cnt_reg   <= req_cnt_next;
            wr_cnt_reg    <= wr_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        fill_bank_next = fill_bank_reg;
        task_bank_next = task_bank_reg;
        exec_busy_next = exec_busy_reg;
        req_cnt_next   = req_cnt_reg;
        wr_cnt_next    = wr_cnt_reg;

        if (ack_ok) begin
            req_cnt_next = (req_cnt_reg == LAST_LINE) ? '0
                                                      : req_cnt_reg + WR_ADDR_WIDTH'(1);
        end
        if (wr_ok) begin
            wr_cnt_next = batch_done ? '0 : wr_cnt_reg + WR_ADDR_WIDTH'(1);
        end

        case (state_reg)
            S_RESET: state_next = S_REQ;
            S_REQ: begin
                if (batch_done) begin
                    state_next = handoff ? S_REQ : S_HOLD;
                end else if (ack_ok && (req_cnt_reg == LAST_LINE)) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (batch_done) begin
                    state_next = handoff ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.task_done) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_RESET;
        endcase

        if (handoff) begin
            task_bank_next = fill_bank_reg;
            fill_bank_next = ~fill_bank_reg;
            exec_busy_next = 1'b1;
        end else if (bus.task_done && exec_busy_reg) begin
            exec_busy_next = 1'b0;
        end
    end

    assign bus.ReqValid   = (state_reg == S_REQ);
    assign bus.ReqLineIdx = req_cnt_reg;
    assign bus.ReqBank    = fill_bank_reg;
    assign bus.task_start = handoff;
    assign bus.task_bank  = task_bank_reg;
    assign bus.Full       = (state_reg == S_RESET) || (state_reg == S_HOLD);
    // RESET counts as empty: nothing is executing and nothing has been written.
    assign bus.Empty      = !exec_busy_reg && (wr_cnt_reg == '0) &&
                            ((state_reg == S_REQ) || (state_reg == S_RESET));

    // Storage: bank select is the top address bit.
    logic [WR_DATA_WIDTH-1:0] rd_line;
    logic [RD_ADDR_WIDTH-1:0] rd_addr;
    logic [SEL_W-1:0]         rd_lane;

    assign rd_addr = bus.RdAddr;

    if (LANE_BITS > 0) begin : g_lane_sel
        assign rd_lane = rd_addr[SEL_W-1:0];
    end else begin : g_no_lane_sel
        assign rd_lane = 1'b0;
    end

    nlb_gram_sdp #(
        .ADDR_WIDTH (WR_ADDR_WIDTH + 1),
        .DEPTH      (2 * (2 ** WR_ADDR_WIDTH)),
        .DATA_WIDTH (WR_DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr ({fill_bank_reg, bus.WrAddr}),
        .wr_data (bus.WrDin),
        .rd_addr ({task_bank_reg, rd_addr[RD_ADDR_WIDTH-1:LANE_BITS]}),
        .rd_data (rd_line)
    );

    tbb_lane_mux #(
        .LINE_WIDTH (WR_DATA_WIDTH),
        .WORD_WIDTH (RD_DATA_WIDTH),
        .LANE_BITS  (LANE_BITS)
    ) u_lane_mux (
        .clk  (clk),
        .lane (rd_lane),
        .line (rd_line),
        .word (bus.RdDout)
    );

`ifdef TBB_PP_ERR_EN
    logic [2:0] err_reg;
    logic       drop_wr, bad_ack, bad_done;

    assign drop_wr  = bus.WrEn && ((state_reg == S_RESET) || (state_reg == S_HOLD));
    assign bad_ack  = bus.ReqAck && (state_reg != S_REQ);
    assign bad_done = bus.task_done && !exec_busy_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_reg <= 3'b000;
        end else begin
            err_reg <= err_reg | {bad_done, bad_ack, drop_wr};
        end
    end
    assign bus.err = err_reg;
`else
    assign bus.err = 3'b000;
`endif
endmodule

// File: tb/tb_tbb_pp.sv
// tb_tbb_pp: self-checking bench for tbb_pp. Two instances share clock/reset:
//   u_a: 4 lines of 512 bits, 32-bit reads (ping-pong, back-to-back, errors)
//   u_b: 3 lines of 64 bits, 32-bit reads (non-power-of-2 line count)
module tb_tbb_pp;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: bank contents plus which bank is filling / executing.
    logic [511:0] mem_a [2][4];
    logic [63:0]  mem_b [2][3];
    bit           m_fill;
    bit           m_exec;
    logic [2:0]   err_exp;

    tbb_pp_if #(.WR_ADDR_WIDTH(3), .WR_DATA_WIDTH(512), .RD_DATA_WIDTH(32),
                .RD_ADDR_WIDTH(7)) bus_a ();
    tbb_pp_if #(.WR_ADDR_WIDTH(2), .WR_DATA_WIDTH(64), .RD_DATA_WIDTH(32),
                .RD_ADDR_WIDTH(3)) bus_b ();

    tbb_pp #(.WR_ADDR_WIDTH(3), .WR_DATA_WIDTH(512), .RD_DATA_WIDTH(32), .NUM_LINES(4))
        u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    tbb_pp #(.WR_ADDR_WIDTH(2), .WR_DATA_WIDTH(64), .RD_DATA_WIDTH(32), .NUM_LINES(3))
        u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [511:0] pat_line(input int ln);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = 32'(ln * 16 + k);
        return v;
    endfunction

    function automatic logic [31:0] exp_a(input bit bank, input int addr);
        logic [511:0] l;
        l = mem_a[bank][addr / 16];
        return l[(addr % 16) * 32 +: 32];
    endfunction

    function automatic logic [31:0] exp_b(input bit bank, input int addr);
        logic [63:0] l;
        l = mem_b[bank][addr / 2];
        return l[(addr % 2) * 32 +: 32];
    endfunction

    task automatic read_a(input int addr);
        bus_a.RdAddr = 7'(addr);
        step();
        chk("rd_a", 512'(bus_a.RdDout), 512'(exp_a(m_exec, addr)));
    endtask

    // Ack four requests, then write four lines; task_start is expected only on
    // the final write, and only when exp_start says the executor is free.
    task automatic fill_a(input bit use_pat, input bit done_last, input bit exp_start);
        logic [511:0] d;
        int ln;
        for (int i = 0; i < 4; i++) begin
            bus_a.ReqAck = 1'b1;
            #1;
            chk("req_valid", 512'(bus_a.ReqValid), 512'(1));
            chk("req_idx", 512'(bus_a.ReqLineIdx), 512'(i));
            chk("req_bank", 512'(bus_a.ReqBank), 512'(m_fill));
            step();
        end
        bus_a.ReqAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ln = use_pat ? i : 3 - i;
            d  = use_pat ? pat_line(ln) : rand_line();
            mem_a[m_fill][ln] = d;
            bus_a.WrEn   = 1'b1;
            bus_a.WrAddr = 3'(ln);
            bus_a.WrDin  = d;
            if (i == 3) bus_a.task_done = done_last;
            #1;
            chk("task_start_fill", 512'(bus_a.task_start), 512'((i == 3) ? exp_start : 1'b0));
            step();
        end
        bus_a.WrEn      = 1'b0;
        bus_a.task_done = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_exp;
        int          addr;
        logic [63:0] d64;

        reset_n = 1'b0;
        bus_a.ReqAck = 1'b0; bus_a.WrEn = 1'b0; bus_a.WrAddr = '0; bus_a.WrDin = '0;
        bus_a.task_done = 1'b0; bus_a.RdAddr = '0;
        bus_b.ReqAck = 1'b0; bus_b.WrEn = 1'b0; bus_b.WrAddr = '0; bus_b.WrDin = '0;
        bus_b.task_done = 1'b0; bus_b.RdAddr = '0;
        m_fill = 1'b0;
        m_exec = 1'b0;
`ifdef TBB_PP_ERR_EN
        err_exp = 3'b101;
`else
        err_exp = 3'b000;
`endif

        // Reset state
        @(negedge clk);
        step();
        step();
        chk("rst_req_valid", 512'(bus_a.ReqValid), 512'(0));
        chk("rst_task_start", 512'(bus_a.task_start), 512'(0));
        chk("rst_full", 512'(bus_a.Full), 512'(1));
        chk("rst_empty", 512'(bus_a.Empty), 512'(1));
        chk("rst_err", 512'(bus_a.err), 512'(0));
        chk("rst_task_bank", 512'(bus_a.task_bank), 512'(0));
        chk("rst_req_bank", 512'(bus_a.ReqBank), 512'(0));

        reset_n = 1'b1;
        step();
        chk("post_rst_valid", 512'(bus_a.ReqValid), 512'(1));
        chk("post_rst_full", 512'(bus_a.Full), 512'(0));
        chk("post_rst_empty", 512'(bus_a.Empty), 512'(1));

        // Single batch into bank 0, immediate handoff
        fill_a(1'b1, 1'b0, 1'b1);
        m_exec = m_fill;
        m_fill = ~m_fill;
        chk("b1_task_bank", 512'(bus_a.task_bank), 512'(0));
        chk("b1_req_bank", 512'(bus_a.ReqBank), 512'(1));
        chk("b1_req_valid", 512'(bus_a.ReqValid), 512'(1));
        chk("b1_empty", 512'(bus_a.Empty), 512'(0));
        chk("b1_err", 512'(bus_a.err), 512'(0));
        read_a(32'h25);
        chk("rd_0x25", 512'(bus_a.RdDout), 512'(32'h25));
        for (int r = 0; r < 5; r++) read_a(int'($urandom_range(0, 63)));

        // Ping-pong: bank 1 fills while bank 0 runs, so it must wait in HOLD
        fill_a(1'b0, 1'b0, 1'b0);
        chk("hold_full", 512'(bus_a.Full), 512'(1));
        chk("hold_req_valid", 512'(bus_a.ReqValid), 512'(0));
        bus_a.WrEn   = 1'b1;
        bus_a.WrAddr = 3'd0;
        bus_a.WrDin  = ~mem_a[m_fill][0];
        #1;
        chk("hold_wr_start", 512'(bus_a.task_start), 512'(0));
        step();
        bus_a.WrEn = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            chk("hold_wait_start", 512'(bus_a.task_start), 512'(0));
            chk("hold_wait_full", 512'(bus_a.Full), 512'(1));
            step();
        end
        addr = int'($urandom_range(0, 63));
        hold_exp = exp_a(m_exec, addr);
        bus_a.RdAddr = 7'(addr);
        bus_a.task_done = 1'b1;
        #1;
        chk("hold_done_start", 512'(bus_a.task_start), 512'(1));
        step();
        bus_a.task_done = 1'b0;
        m_exec = m_fill;
        m_fill = ~m_fill;
        chk("handoff_cycle_rd_old_bank", 512'(bus_a.RdDout), 512'(hold_exp));
        chk("pp_task_bank", 512'(bus_a.task_bank), 512'(1));
        chk("pp_req_bank", 512'(bus_a.ReqBank), 512'(0));
        for (int k = 0; k < 2; k++) read_a(k);
        for (int r = 0; r < 4; r++) read_a(int'($urandom_range(0, 63)));

        // Back-to-back: last write of bank 0 coincides with task_done of bank 1
        fill_a(1'b0, 1'b1, 1'b1);
        m_exec = m_fill;
        m_fill = ~m_fill;
        chk("b2b_task_bank", 512'(bus_a.task_bank), 512'(0));
        chk("b2b_req_bank", 512'(bus_a.ReqBank), 512'(1));
        chk("b2b_req_valid", 512'(bus_a.ReqValid), 512'(1));
        chk("b2b_full", 512'(bus_a.Full), 512'(0));
        chk("b2b_empty_busy", 512'(bus_a.Empty), 512'(0));
        for (int r = 0; r < 4; r++) read_a(int'($urandom_range(0, 63)));

        // task_done finishes the run; a second one arrives while idle
        bus_a.task_done = 1'b1;
        step();
        bus_a.task_done = 1'b0;
        chk("idle_empty", 512'(bus_a.Empty), 512'(1));
        bus_a.task_done = 1'b1;
        #1;
        chk("idle_done_start", 512'(bus_a.task_start), 512'(0));
        step();
        bus_a.task_done = 1'b0;
        chk("err_flags", 512'(bus_a.err), 512'(err_exp));
        step();
        chk("err_sticky", 512'(bus_a.err), 512'(err_exp));
        read_a(int'($urandom_range(0, 63)));

        // Reset in the middle of a fill
        for (int i = 0; i < 2; i++) begin
            bus_a.ReqAck = 1'b1;
            #1;
            chk("mid_req_idx", 512'(bus_a.ReqLineIdx), 512'(i));
            step();
        end
        bus_a.ReqAck = 1'b0;
        reset_n = 1'b0;
        step();
        chk("midrst_req_valid", 512'(bus_a.ReqValid), 512'(0));
        chk("midrst_err", 512'(bus_a.err), 512'(0));
        chk("midrst_task_bank", 512'(bus_a.task_bank), 512'(0));
        reset_n = 1'b1;
        step();
        m_fill = 1'b0;
        m_exec = 1'b0;
        chk("midrst_valid_again", 512'(bus_a.ReqValid), 512'(1));
        chk("midrst_req_idx", 512'(bus_a.ReqLineIdx), 512'(0));
        chk("midrst_req_bank", 512'(bus_a.ReqBank), 512'(0));

        // Non-power-of-2 line count on u_b
        for (int i = 0; i < 3; i++) begin
            bus_b.ReqAck = 1'b1;
            #1;
            chk("b_req_idx", 512'(bus_b.ReqLineIdx), 512'(i));
            chk("b_req_bank", 512'(bus_b.ReqBank), 512'(0));
            step();
        end
        bus_b.ReqAck = 1'b0;
        chk("b_fill_req_valid", 512'(bus_b.ReqValid), 512'(0));
        for (int i = 0; i < 3; i++) begin
            d64 = {$urandom(), $urandom()};
            mem_b[0][i] = d64;
            bus_b.WrEn   = 1'b1;
            bus_b.WrAddr = 2'(i);
            bus_b.WrDin  = d64;
            #1;
            chk("b_task_start", 512'(bus_b.task_start), 512'((i == 2) ? 1'b1 : 1'b0));
            step();
        end
        bus_b.WrEn = 1'b0;
        chk("b_wrap_valid", 512'(bus_b.ReqValid), 512'(1));
        chk("b_wrap_idx", 512'(bus_b.ReqLineIdx), 512'(0));
        chk("b_req_bank_after", 512'(bus_b.ReqBank), 512'(1));
        chk("b_task_bank", 512'(bus_b.task_bank), 512'(0));
        for (int r = 0; r < 6; r++) begin
            addr = int'($urandom_range(0, 5));
            bus_b.RdAddr = 3'(addr);
            step();
            chk("rd_b", 512'(bus_b.RdDout), 512'(exp_b(1'b0, addr)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
